lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side checker for the 4-bit LFSR pattern generator. It consumes the generator's full 4-bit state word stream and locks onto the sequence by self-seeding from received words. Once locked, it predicts each next word, flags and counts mismatches, and drops lock after sustained errors. It sits at the far end of a test link or loopback path and reports link integrity to the debug/status logic.

## Interface
- LOCK_CNT, 3, consecutive correct words (seed word included) required to declare lock; legal range ≥ 2
- LOSS_CNT, 4, consecutive mismatching words while locked that force loss of lock; legal range ≥ 1
- ERR_W, 16, width of the error counter
- clk_i  input  1  single clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  data_i holds a word this cycle; when low, all state holds
- data_i  input  4  received LFSR state word
- clear_i  input  1  synchronous clear of err_cnt_o
- locked_o  output  1  checker locked to the sequence
- error_o  output  1  one-cycle pulse: mismatch detected while locked
- zero_o  output  1  one-cycle pulse: all-zero word received (illegal lock-up state)
- err_cnt_o  output  ERR_W  saturating mismatch count

## Operation
- Successor function f(s) = {s[2], s[1]^s[3], s[0]^s[3], s[3]} (bit 3..0), identical to the generator recurrence.
- Legal cycle from reset seed: F→9→5→A→3→6→C→F (period 7).
- Registers: state, exp (expected next word), match_cnt, miss_cnt, err_cnt.
- States:
  - HUNT: on valid, if data_i != 0, then exp←f(data_i), match_cnt←1, →CHECK. If data_i == 0, pulse zero_o and stay.
  - CHECK: on valid, if data_i == exp, then exp←f(data_i) and match_cnt++. When the incremented count equals LOCK_CNT, →LOCKED, miss_cnt←0.
  - CHECK, on a mismatching nonzero word: reseed with exp←f(data_i), match_cnt←1, stay in CHECK.
  - CHECK, on a zero word: pulse zero_o, →HUNT.
  - LOCKED, on valid and match: exp←f(exp), miss_cnt←0.
  - LOCKED, on valid and mismatch: flywheel with exp←f(exp) (no resync), pulse error_o, err_cnt++ (saturates at 2^ERR_W−1), miss_cnt++. When the incremented count equals LOSS_CNT, →HUNT.
  - LOCKED, on a zero word: counts as a mismatch and also pulses zero_o.
- Mismatches in HUNT and CHECK never touch err_cnt or error_o.
- clear_i sets err_cnt←0. If it coincides with an increment, clear wins and the result is 0.
- locked_o = (state == LOCKED).

## Timing
- All outputs are registered. Reset values: locked_o=0, error_o=0, zero_o=0, err_cnt_o=0. Internal reset values: state=HUNT, exp=0, match_cnt=0, miss_cnt=0.
- Reset takes effect immediately (asynchronous) regardless of state, including mid-LOCKED.
- error_o and zero_o assert in the cycle after the rising edge that samples the offending word, for exactly one cycle. err_cnt_o updates on the same edge.
- Lock latency: locked_o rises on the edge sampling the LOCK_CNT-th consecutive correct word.
- Loss latency: locked_o falls on the edge sampling the LOSS_CNT-th consecutive mismatch. That mismatch still pulses error_o and increments err_cnt.
- valid_i low: no state, counter or expectation advance; pulse outputs are 0.
- Back-to-back valid words at full rate are supported; there is no backpressure.

## Test plan
- Lock from reset: release rst_i, then feed F,9,5,A,3,6,C,F with valid every cycle. locked_o rises after the edge sampling 5 and stays high; err_cnt_o=0; error_o never pulses.
- Single error: after lock, replace one 3 with 0, then continue with 6,C,F. Required: one error_o pulse plus a zero_o pulse; err_cnt_o=1; locked_o stays high; 6 is accepted with no further error.
- Loss and relock: after lock, send 4 words of 7. Required: err_cnt_o=4 and locked_o falls after the 4th. Then send A,3,6 and locked_o rises after 6; err_cnt_o is still 4.
- Valid gaps: repeat the lock test with valid_i low on random cycles (data_i garbage during gaps). Required: identical locked_o and err_cnt_o progression counted in valid words only.
- Saturation and clear (ERR_W=4): after lock, alternate bad/good words for 20 errors. err_cnt_o sticks at 15 and locked_o stays high. Assert clear_i coincident with a bad word; next cycle err_cnt_o=0.
- Reset mid-operation: assert rst_i while locked with err_cnt_o=5. locked_o=0 and err_cnt_o=0 without waiting for a clock edge; after release, the checker hunts again.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit LFSR pattern generator.
// Self-seeds from received words, locks after LOCK_CNT correct words, and counts mismatches while locked.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | no seed yet; waiting for a nonzero word to seed from
// CHECK   | seeded; counting consecutive correct words toward lock
// LOCKED  | tracking the sequence; flywheels through mismatches
module lfsr_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_o,
  output logic             zero_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_V = LW'(LOSS_CNT);

  function automatic logic [3:0] succ(input logic [3:0] s);
    return {s[2], s[1] ^ s[3], s[0] ^ s[3], s[3]};
  endfunction

  logic [1:0]       state, state_nxt;
  logic [3:0]       exp, exp_nxt;
  logic [MW-1:0]    match_cnt, match_nxt, match_inc;
  logic [LW-1:0]    miss_cnt, miss_nxt, miss_inc;
  logic [ERR_W-1:0] err_nxt;
  logic             error_nxt, zero_nxt, err_inc;
  logic             is_zero, is_match;

  assign is_zero   = (data_i == 4'h0);
  assign is_match  = (data_i == exp);
  assign match_inc = match_cnt + MW'(1);
  assign miss_inc  = miss_cnt + LW'(1);

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    error_nxt = 1'b0;
    zero_nxt  = 1'b0;
    err_inc   = 1'b0;
    if (valid_i) begin
      case (state)
        HUNT: begin
          if (is_zero) begin
            zero_nxt = 1'b1;
          end else begin
            exp_nxt   = succ(data_i);
            match_nxt = MW'(1);
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (is_zero) begin
            zero_nxt  = 1'b1;
            state_nxt = HUNT;
          end else if (is_match) begin
            exp_nxt   = succ(data_i);
            match_nxt = match_inc;
            if (match_inc == LOCK_V) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            exp_nxt   = succ(data_i);
            match_nxt = MW'(1);
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so a corrupted word never resyncs us.
          exp_nxt  = succ(exp);
          zero_nxt = is_zero;
          if (is_match) begin
            miss_nxt = '0;
          end else begin
            error_nxt = 1'b1;
            err_inc   = 1'b1;
            miss_nxt  = miss_inc;
            if (miss_inc == LOSS_V) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    err_nxt = err_cnt_o;
    if (clear_i)
      err_nxt = '0;
    else if (err_inc && (err_cnt_o != {ERR_W{1'b1}}))
      err_nxt = err_cnt_o + ERR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= HUNT;
      exp       <= 4'h0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_o  <= 1'b0;
      error_o   <= 1'b0;
      zero_o    <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      exp       <= exp_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked_o  <= (state_nxt == LOCKED);
      error_o   <= error_nxt;
      zero_o    <= zero_nxt;
      err_cnt_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed test-plan steps plus randomized words against a behavioural model.
// Two instances share stimulus: default 16-bit counter and a 4-bit counter for saturation.
module tb_lfsr_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  data_i;
  logic        clear_i;
  logic        locked16, error16, zero16;
  logic [15:0] err16;
  logic        locked4, error4, zero4;
  logic [3:0]  err4;

  lfsr_checker u_dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .locked_o(locked16), .error_o(error16), .zero_o(zero16), .err_cnt_o(err16)
  );

  lfsr_checker #(.ERR_W(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .locked_o(locked4), .error_o(error4), .zero_o(zero4), .err_cnt_o(err4)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;

  // Behavioural model: seeded/locked flags, run length of matches, miss run, unbounded error total.
  bit         m_seeded, m_locked, m_err, m_zero;
  logic [3:0] m_exp;
  int         m_run, m_miss, m_total;

  function automatic logic [3:0] nxt(input logic [3:0] s);
    int v, r;
    v = int'(s);
    r = ((v * 2) % 16) + v / 8;
    if (v >= 8) r = r ^ 6;
    return 4'(r);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_err = 0; m_zero = 0;
    m_exp = 4'h0; m_run = 0; m_miss = 0; m_total = 0;
  endtask

  task automatic model(input logic v, input logic [3:0] d, input logic c);
    m_err = 0;
    m_zero = 0;
    if (v) begin
      if (m_locked) begin
        m_zero = (d == 4'h0);
        if (d == m_exp) m_miss = 0;
        else begin
          m_err = 1;
          m_total++;
          m_miss++;
          if (m_miss == 4) begin m_locked = 0; m_seeded = 0; end
        end
        m_exp = nxt(m_exp);
      end else if (d == 4'h0) begin
        m_zero = 1;
        m_seeded = 0;
      end else if (m_seeded && d == m_exp) begin
        m_run++;
        m_exp = nxt(d);
        if (m_run == 3) begin m_locked = 1; m_miss = 0; end
      end else begin
        m_seeded = 1;
        m_run = 1;
        m_exp = nxt(d);
      end
    end
    if (c) m_total = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("locked16", 32'(locked16), 32'(m_locked));
    check("locked4",  32'(locked4),  32'(m_locked));
    check("error16",  32'(error16),  32'(m_err));
    check("error4",   32'(error4),   32'(m_err));
    check("zero16",   32'(zero16),   32'(m_zero));
    check("zero4",    32'(zero4),    32'(m_zero));
    check("err_cnt16", 32'(err16), 32'(sat(m_total, 65535)));
    check("err_cnt4",  32'(err4),  32'(sat(m_total, 15)));
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk_i);
    valid_i = v; data_i = d; clear_i = c;
    @(posedge clk_i);
    #1;
    model(v, d, c);
    vectors++;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0; data_i = 4'h0; clear_i = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [3:0] seq [8] = '{4'hF, 4'h9, 4'h5, 4'hA, 4'h3, 4'h6, 4'hC, 4'hF};
  logic [3:0] g, d;
  logic       v, c;
  int         r;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = 4'h0; clear_i = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Lock from reset
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0);
      if (i == 1) check("pre_lock", 32'(locked16), 32'(0));
      if (i == 2) check("lock_at_5", 32'(locked16), 32'(1));
    end
    check("lock_err_cnt", 32'(err16), 32'(0));

    // Single error: zero replaces a 3
    step(1'b1, 4'h9, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    check("single_err_pulse", 32'({error16, zero16}), 32'(3));
    step(1'b1, 4'h6, 1'b0);
    check("single_err_6_ok", 32'(error16), 32'(0));
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    check("single_err_cnt", 32'(err16), 32'(1));
    check("single_err_locked", 32'(locked16), 32'(1));

    // Loss and relock
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h7, 1'b0);
      if (i == 2) check("loss_still_locked", 32'(locked16), 32'(1));
    end
    check("loss_unlocked", 32'(locked16), 32'(0));
    check("loss_err_cnt", 32'(err16), 32'(5));
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    check("relock_pending", 32'(locked16), 32'(0));
    step(1'b1, 4'h6, 1'b0);
    check("relock", 32'(locked16), 32'(1));
    check("relock_err_cnt", 32'(err16), 32'(5));
    step(1'b0, 4'h0, 1'b1);
    check("clear_idle", 32'(err16), 32'(0));

    // Valid gaps with garbage data
    do_reset();
    g = 4'hF;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) begin step(1'b1, g, 1'b0); g = nxt(g); end
      else step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    end
    check("gaps_locked", 32'(locked16), 32'(1));
    check("gaps_err_cnt", 32'(err16), 32'(0));

    // Random mix of good words, corruption, zeros, reseeds and clears
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 11));
      c = ($urandom_range(0, 39) == 0);
      if (r == 2) g = 4'($urandom_range(1, 15));
      d = (r == 0) ? 4'($urandom_range(0, 15)) : (r == 1) ? 4'h0 : g;
      step(v, v ? d : 4'($urandom_range(0, 15)), c);
      if (v) g = nxt(g);
    end

    // Saturation and clear on the 4-bit counter
    do_reset();
    g = 4'hF;
    for (int i = 0; i < 3; i++) begin step(1'b1, g, 1'b0); g = nxt(g); end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, g ^ 4'h1, 1'b0); g = nxt(g);
      step(1'b1, g, 1'b0); g = nxt(g);
    end
    check("sat_cnt4", 32'(err4), 32'(15));
    check("sat_locked", 32'(locked4), 32'(1));
    step(1'b1, g ^ 4'h1, 1'b1); g = nxt(g);
    check("clear_wins", 32'(err4), 32'(0));
    check("clear_err_pulse", 32'(error4), 32'(1));

    // Reset mid-operation with err_cnt = 5
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g, 1'b0); g = nxt(g);
      step(1'b1, g ^ 4'h1, 1'b0); g = nxt(g);
    end
    check("pre_reset_cnt", 32'(err4), 32'(5));
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_locked", 32'(locked16), 32'(0));
    check("async_rst_cnt", 32'(err4), 32'(0));
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    check("hunt_after_rst", 32'(locked16), 32'(0));
    step(1'b1, 4'hC, 1'b0);
    check("relock_after_rst", 32'(locked16), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
